// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
`default_nettype none

package pipe_hazard_ctrl_pkg;

  typedef enum logic {RUN = 1'b0, REDIR_PEND = 1'b1} pipe_state_e;

  typedef struct packed {
    logic en;
    logic clr;
  } stage_ctrl_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam stage_ctrl_t STAGE_FLOW = '{en: 1'b1, clr: 1'b0};

  // True when an ID source register is actually read and matches the EX destination.
  function automatic logic src_hit(input logic use_src, input logic [4:0] rs, input logic [4:0] rd);
    return use_src & (rs == rd);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// Up-counter that stops at all-ones instead of wrapping.
`default_nettype none

module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         synclr_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] ONE = 1;

  always_ff @(posedge clk_i or negedge synclr_ni) begin
    if (!synclr_ni) begin
      cnt_o <= '0;
    end else if (inc_i && !(&cnt_o)) begin
      cnt_o <= cnt_o + ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stage enables/clears, PC enable and redirect.
`default_nettype none

import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             synclr_ni,
  input  logic             imem_ready_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_memrd_i,
  input  logic             ex_redirect_i,
  input  logic [XLEN-1:0]  ex_target_i,
  output logic             pc_en_o,
  output logic             redir_o,
  output logic [XLEN-1:0]  redir_tgt_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_clr_o,
  output logic             id_ex_clr_o,
  output logic             ex_mem_clr_o,
  output logic             mem_wb_clr_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  pipe_state_e     state;
  pipe_state_e     state_nx;
  logic [XLEN-1:0] tgt_q;
  stage_ctrl_t     if_id, id_ex, ex_mem, mem_wb;
  logic            load_use;
  logic            dwait;
  logic            accept;

  assign load_use = ex_memrd_i & (ex_rd_i != REG_X0) &
                    (src_hit(id_use_rs1_i, id_rs1_i, ex_rd_i) |
                     src_hit(id_use_rs2_i, id_rs2_i, ex_rd_i));
  assign dwait    = dmem_req_i & ~dmem_ready_i;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    pc_en_o  = 1'b1;
    redir_o  = 1'b0;
    if_id    = STAGE_FLOW;
    id_ex    = STAGE_FLOW;
    ex_mem   = STAGE_FLOW;
    mem_wb   = STAGE_FLOW;
    if (dwait) begin
      // EX is frozen, so a redirect it holds will be presented again once MEM completes.
      pc_en_o    = 1'b0;
      if_id.en   = 1'b0;
      id_ex.en   = 1'b0;
      ex_mem.en  = 1'b0;
      mem_wb.clr = 1'b1;
    end else if (state == RUN && ex_redirect_i) begin
      accept    = 1'b1;
      if_id.clr = 1'b1;
      id_ex.clr = 1'b1;
      if (imem_ready_i) begin
        redir_o = 1'b1;
      end else begin
        pc_en_o  = 1'b0;
        state_nx = REDIR_PEND;
      end
    end else if (state == REDIR_PEND) begin
      if_id.clr = 1'b1;
      if (imem_ready_i) begin
        redir_o  = 1'b1;
        state_nx = RUN;
      end else begin
        pc_en_o = 1'b0;
      end
    end else if (load_use) begin
      pc_en_o   = 1'b0;
      if_id.en  = 1'b0;
      id_ex.clr = 1'b1;
    end else if (!imem_ready_i) begin
      pc_en_o   = 1'b0;
      if_id.clr = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge synclr_ni) begin
    if (!synclr_ni) begin
      state <= RUN;
      tgt_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        tgt_q <= ex_target_i;
      end
    end
  end

  // Same-cycle redirect needs the target before it is registered.
  assign redir_tgt_o  = accept ? ex_target_i : tgt_q;

  assign if_id_en_o   = if_id.en;
  assign id_ex_en_o   = id_ex.en;
  assign ex_mem_en_o  = ex_mem.en;
  assign mem_wb_en_o  = mem_wb.en;
  assign if_id_clr_o  = if_id.clr;
  assign id_ex_clr_o  = id_ex.clr;
  assign ex_mem_clr_o = ex_mem.clr;
  assign mem_wb_clr_o = mem_wb.clr;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i     (clk_i),
    .synclr_ni (synclr_ni),
    .inc_i     (~pc_en_o),
    .cnt_o     (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i     (clk_i),
    .synclr_ni (synclr_ni),
    .inc_i     (accept),
    .cnt_o     (flush_cnt_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; counters built 4 bits wide to reach saturation quickly.
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  localparam logic [3:0] EN_ALL  = 4'b1111;
  localparam logic [3:0] EN_LU   = 4'b0111;
  localparam logic [3:0] EN_DW   = 4'b0001;
  localparam logic [3:0] NO_CLR  = 4'b0000;
  localparam logic [3:0] C_IFID  = 4'b1000;
  localparam logic [3:0] C_IDEX  = 4'b0100;
  localparam logic [3:0] C_FLUSH = 4'b1100;
  localparam logic [3:0] C_MEMWB = 4'b0001;

  logic          clk = 1'b0;
  logic          synclr_n;
  logic          imem_ready, dmem_req, dmem_ready;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          use_rs1, use_rs2, ex_memrd, ex_redirect;
  logic [31:0]   ex_target;
  logic          pc_en, redir;
  logic [31:0]   redir_tgt;
  logic          if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;
  logic [41:0] expq[$];
  logic [41:0] obs;
  logic [41:0] got;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(32), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .synclr_ni     (synclr_n),
    .imem_ready_i  (imem_ready),
    .dmem_req_i    (dmem_req),
    .dmem_ready_i  (dmem_ready),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (use_rs1),
    .id_use_rs2_i  (use_rs2),
    .ex_rd_i       (ex_rd),
    .ex_memrd_i    (ex_memrd),
    .ex_redirect_i (ex_redirect),
    .ex_target_i   (ex_target),
    .pc_en_o       (pc_en),
    .redir_o       (redir),
    .redir_tgt_o   (redir_tgt),
    .if_id_en_o    (if_id_en),
    .id_ex_en_o    (id_ex_en),
    .ex_mem_en_o   (ex_mem_en),
    .mem_wb_en_o   (mem_wb_en),
    .if_id_clr_o   (if_id_clr),
    .id_ex_clr_o   (id_ex_clr),
    .ex_mem_clr_o  (ex_mem_clr),
    .mem_wb_clr_o  (mem_wb_clr),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  assign obs = {pc_en, redir, redir_tgt,
                if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr};

  function automatic logic [41:0] mk(input logic p, input logic r, input logic [31:0] t,
                                     input logic [3:0] e, input logic [3:0] c);
    return {p, r, t, e, c};
  endfunction

  task automatic idle();
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
    id_rs1 = 5'd1; id_rs2 = 5'd2; use_rs1 = 1'b0; use_rs2 = 1'b0;
    ex_rd = 5'd3; ex_memrd = 1'b0; ex_redirect = 1'b0; ex_target = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    synclr_n = 1'b0;
    next_cycle();
    synclr_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    synclr_n = 1'b0;
    #1;
    expq.push_back(mk(1'b1, 1'b0, 32'h0, EN_ALL, NO_CLR));
    got = expq.pop_front();
    checks++;
    if (obs !== got) begin errors++; $display("FAIL rst_outputs got=%h exp=%h", obs, got); end
    imem_ready = 1'b0;
    next_cycle();
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++; $display("FAIL rst_counters stall=%0d flush=%0d exp=0/0", stall_cnt, flush_cnt);
    end
    synclr_n = 1'b1;
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memrd = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; use_rs1 = 1'b1;
    expq.push_back(mk(1'b0, 1'b0, 32'h0, EN_LU, C_IDEX));
    @(negedge clk); got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL lu_rs1 got=%h exp=%h", obs, got); end
    next_cycle();
    ex_memrd = 1'b0;
    expq.push_back(mk(1'b1, 1'b0, 32'h0, EN_ALL, NO_CLR));
    @(negedge clk); got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL lu_release got=%h exp=%h", obs, got); end
    checks++;
    if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    next_cycle();
    ex_memrd = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; use_rs1 = 1'b0; id_rs2 = 5'd7; use_rs2 = 1'b1;
    expq.push_back(mk(1'b0, 1'b0, 32'h0, EN_LU, C_IDEX));
    @(negedge clk); got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL lu_rs2 got=%h exp=%h", obs, got); end
    next_cycle();
    use_rs2 = 1'b0;
    expq.push_back(mk(1'b1, 1'b0, 32'h0, EN_ALL, NO_CLR));
    @(negedge clk); got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL lu_unused_src got=%h exp=%h", obs, got); end
    next_cycle();
    checks++;
    if (stall_cnt !== 4'd2) begin errors++; $display("FAIL lu_stall_cnt2 got=%0d exp=2", stall_cnt); end
    idle();
  endtask

  task automatic test_x0_load();
    ex_memrd = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; use_rs1 = 1'b1;
    expq.push_back(mk(1'b1, 1'b0, 32'h0, EN_ALL, NO_CLR));
    @(negedge clk); got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL x0_load got=%h exp=%h", obs, got); end
    next_cycle();
    checks++;
    if (stall_cnt !== 4'd2) begin errors++; $display("FAIL x0_stall_cnt got=%0d exp=2", stall_cnt); end
    idle();
  endtask

  task automatic test_redirect_ready();
    do_reset();
    ex_redirect = 1'b1; ex_target = 32'h0000_0040;
    expq.push_back(mk(1'b1, 1'b1, 32'h40, EN_ALL, C_FLUSH));
    @(negedge clk); got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL redir_ready got=%h exp=%h", obs, got); end
    next_cycle();
    idle();
    expq.push_back(mk(1'b1, 1'b0, 32'h40, EN_ALL, NO_CLR));
    @(negedge clk); got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL redir_after got=%h exp=%h", obs, got); end
    checks++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL redir_counts flush=%0d stall=%0d exp=1/0", flush_cnt, stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_redirect_miss();
    do_reset();
    ex_redirect = 1'b1; ex_target = 32'h80; imem_ready = 1'b0;
    expq.push_back(mk(1'b0, 1'b0, 32'h80, EN_ALL, C_FLUSH));
    @(negedge clk); got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL miss_accept got=%h exp=%h", obs, got); end
    next_cycle();
    ex_redirect = 1'b0; ex_target = 32'h0;
    for (int i = 0; i < 2; i++) begin
      expq.push_back(mk(1'b0, 1'b0, 32'h80, EN_ALL, C_IFID));
      @(negedge clk); got = expq.pop_front(); checks++;
      if (obs !== got) begin errors++; $display("FAIL miss_pend%0d got=%h exp=%h", i, obs, got); end
      next_cycle();
    end
    imem_ready = 1'b1;
    expq.push_back(mk(1'b1, 1'b1, 32'h80, EN_ALL, C_IFID));
    @(negedge clk); got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL miss_ready got=%h exp=%h", obs, got); end
    next_cycle();
    expq.push_back(mk(1'b1, 1'b0, 32'h80, EN_ALL, NO_CLR));
    @(negedge clk); got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL miss_back_run got=%h exp=%h", obs, got); end
    checks++;
    if (stall_cnt !== 4'd3 || flush_cnt !== 4'd1) begin
      errors++; $display("FAIL miss_counts stall=%0d flush=%0d exp=3/1", stall_cnt, flush_cnt);
    end
    next_cycle();
  endtask

  task automatic test_dwait_redirect();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1; ex_target = 32'h40;
    for (int i = 0; i < 2; i++) begin
      expq.push_back(mk(1'b0, 1'b0, 32'h0, EN_DW, C_MEMWB));
      @(negedge clk); got = expq.pop_front(); checks++;
      if (obs !== got) begin errors++; $display("FAIL dwait%0d got=%h exp=%h", i, obs, got); end
      next_cycle();
    end
    checks++;
    if (flush_cnt !== 4'd0) begin errors++; $display("FAIL dwait_flush got=%0d exp=0", flush_cnt); end
    dmem_ready = 1'b1;
    expq.push_back(mk(1'b1, 1'b1, 32'h40, EN_ALL, C_FLUSH));
    @(negedge clk); got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL dwait_release got=%h exp=%h", obs, got); end
    next_cycle();
    idle();
    checks++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd2) begin
      errors++; $display("FAIL dwait_counts flush=%0d stall=%0d exp=1/2", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // load-use outranks a concurrent fetch miss
    ex_memrd = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; use_rs2 = 1'b1; imem_ready = 1'b0;
    expq.push_back(mk(1'b0, 1'b0, 32'h0, EN_LU, C_IDEX));
    @(negedge clk); got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL prio_lu_over_miss got=%h exp=%h", obs, got); end
    next_cycle();
    idle();
    for (int i = 0; i < 2; i++) begin
      ex_redirect = 1'b1; ex_target = 32'h100 + 32'(i) * 32'h10;
      expq.push_back(mk(1'b1, 1'b1, 32'h100 + 32'(i) * 32'h10, EN_ALL, C_FLUSH));
      @(negedge clk); got = expq.pop_front(); checks++;
      if (obs !== got) begin errors++; $display("FAIL b2b_redir%0d got=%h exp=%h", i, obs, got); end
      next_cycle();
    end
    idle();
    checks++;
    if (flush_cnt !== 4'd2 || redir_tgt !== 32'h110) begin
      errors++; $display("FAIL b2b_state flush=%0d tgt=%h exp=2/00000110", flush_cnt, redir_tgt);
    end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      expq.push_back(mk(1'b0, 1'b0, 32'h0, EN_ALL, C_IFID));
      @(negedge clk); got = expq.pop_front(); checks++;
      if (obs !== got) begin errors++; $display("FAIL sat_miss%0d got=%h exp=%h", i, obs, got); end
      next_cycle();
    end
    checks++;
    if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall got=%0d exp=15", stall_cnt); end
    ex_redirect = 1'b1; ex_target = 32'hC0;
    next_cycle();
    ex_redirect = 1'b0; imem_ready = 1'b1;
    #1;
    expq.push_back(mk(1'b1, 1'b1, 32'hC0, EN_ALL, C_IFID));
    got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL sat_pend got=%h exp=%h", obs, got); end
    synclr_n = 1'b0;
    #1;
    expq.push_back(mk(1'b1, 1'b0, 32'h0, EN_ALL, NO_CLR));
    got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL async_rst got=%h exp=%h", obs, got); end
    checks++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      errors++; $display("FAIL async_rst_cnt stall=%0d flush=%0d exp=0/0", stall_cnt, flush_cnt);
    end
    next_cycle();
    synclr_n = 1'b1;
    expq.push_back(mk(1'b1, 1'b0, 32'h0, EN_ALL, NO_CLR));
    @(negedge clk); got = expq.pop_front(); checks++;
    if (obs !== got) begin errors++; $display("FAIL post_rst_run got=%h exp=%h", obs, got); end
  endtask

  initial begin
    idle();
    synclr_n = 1'b0;
    test_reset();
    test_load_use();
    test_x0_load();
    test_redirect_ready();
    test_redirect_miss();
    test_dwait_redirect();
    test_back_to_back();
    test_saturation_reset();
    checks++;
    if (expq.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", expq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
